// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the fetch stage.
// Presents o_pc over a valid/ready handshake, advances by INC on each accepted
// fetch, applies trap > branch > pending redirect priority, buffers one redirect
// that arrives while a fetch is stalled, and supports halt/resume.
// Build option PC_MISALIGN_CHK_EN: misaligned branch targets are dropped and
// reported on o_misalign/o_misalign_pc instead of being silently aligned.
module pc_gen #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = {XLEN{1'b0}},
  parameter int unsigned     INC        = 4,
  parameter int unsigned     ALIGN_BITS = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_fetch_ready,
  output logic            o_fetch_valid,
  output logic [XLEN-1:0] o_pc,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_pc,
  input  logic            i_br_valid,
  input  logic [XLEN-1:0] i_br_pc,
  input  logic            i_halt,
  output logic            o_halted,
  output logic            o_misalign,
  output logic [XLEN-1:0] o_misalign_pc
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-ALIGN_BITS){1'b1}}, {ALIGN_BITS{1'b0}}};
  localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);

  state_e            state_r;
  logic              valid_r;
  logic              halted_r;
  logic [XLEN-1:0]   pc_r;
  logic              pend_v_r;
  logic [XLEN-1:0]   pend_pc_r;
  logic              pend_trap_r;

  logic              fire_s;
  logic              stall_s;
  logic [XLEN-1:0]   trap_tgt_s;
  logic              br_take_s;
  logic [XLEN-1:0]   br_tgt_s;
  logic [XLEN-1:0]   pc_nxt_s;
  logic              pend_v_nxt_s;
  logic [XLEN-1:0]   pend_pc_nxt_s;
  logic              pend_trap_nxt_s;

  assign fire_s     = valid_r & i_fetch_ready;
  assign stall_s    = valid_r & ~i_fetch_ready;
  assign trap_tgt_s = i_trap_pc & ALIGN_MASK;

`ifdef PC_MISALIGN_CHK_EN
  logic            br_misal_s;
  logic            misalign_r;
  logic [XLEN-1:0] misalign_pc_r;

  assign br_misal_s = |(i_br_pc & ~ALIGN_MASK);
  assign br_take_s  = i_br_valid & ~br_misal_s;
  assign br_tgt_s   = i_br_pc;

  // One-cycle report of a dropped misaligned branch target
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      misalign_r    <= 1'b0;
      misalign_pc_r <= {XLEN{1'b0}};
    end else begin
      misalign_r    <= i_br_valid & br_misal_s;
      misalign_pc_r <= (i_br_valid & br_misal_s) ? i_br_pc : {XLEN{1'b0}};
    end
  end

  assign o_misalign    = misalign_r;
  assign o_misalign_pc = misalign_pc_r;
`else
  assign br_take_s     = i_br_valid;
  assign br_tgt_s      = i_br_pc & ALIGN_MASK;
  assign o_misalign    = 1'b0;
  assign o_misalign_pc = {XLEN{1'b0}};
`endif

  // Next-PC selection and pending-redirect capture; o_pc is frozen while stalled
  always_comb begin
    pc_nxt_s        = pc_r;
    pend_v_nxt_s    = 1'b0;
    pend_pc_nxt_s   = pend_pc_r;
    pend_trap_nxt_s = pend_trap_r;
    if (stall_s) begin
      pend_v_nxt_s = pend_v_r;
      if (i_trap_valid) begin
        // A trap always replaces whatever is pending
        pend_v_nxt_s    = 1'b1;
        pend_pc_nxt_s   = trap_tgt_s;
        pend_trap_nxt_s = 1'b1;
      end else if (br_take_s && !(pend_v_r && pend_trap_r)) begin
        // A branch may replace a pending branch but never a pending trap
        pend_v_nxt_s    = 1'b1;
        pend_pc_nxt_s   = br_tgt_s;
        pend_trap_nxt_s = 1'b0;
      end else begin
        pend_v_nxt_s = pend_v_r;
      end
    end else begin
      // Not stalled: either fire in RUN or no handshake outstanding (BOOT/HALT)
      if (i_trap_valid) begin
        pc_nxt_s = trap_tgt_s;
      end else if (br_take_s) begin
        pc_nxt_s = br_tgt_s;
      end else if (pend_v_r) begin
        pc_nxt_s = pend_pc_r;
      end else if (fire_s) begin
        pc_nxt_s = pc_r + INC_W;
      end else begin
        pc_nxt_s = pc_r;
      end
    end
  end

  // PC and pending-slot registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_r        <= RESET_ADDR;
      pend_v_r    <= 1'b0;
      pend_pc_r   <= {XLEN{1'b0}};
      pend_trap_r <= 1'b0;
    end else begin
      pc_r        <= pc_nxt_s;
      pend_v_r    <= pend_v_nxt_s;
      pend_pc_r   <= pend_pc_nxt_s;
      pend_trap_r <= pend_trap_nxt_s;
    end
  end

  // Fetch-control FSM; valid and halted are registered alongside the state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= ST_BOOT;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_BOOT, ST_HALT: begin
          if (i_halt) begin
            state_r  <= ST_HALT;
            valid_r  <= 1'b0;
            halted_r <= 1'b1;
          end else begin
            state_r  <= ST_RUN;
            valid_r  <= 1'b1;
            halted_r <= 1'b0;
          end
        end
        ST_RUN: begin
          // A stalled request must complete before halting
          if (i_halt && !stall_s) begin
            state_r  <= ST_HALT;
            valid_r  <= 1'b0;
            halted_r <= 1'b1;
          end else begin
            state_r  <= ST_RUN;
            valid_r  <= 1'b1;
            halted_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_BOOT;
          valid_r  <= 1'b0;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_fetch_valid = valid_r;
  assign o_pc          = pc_r;
  assign o_halted      = halted_r;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vector table for the documented scenarios, a hand-written
// reset-mid-handshake sequence, then randomized stimulus against a rule-level model.
module tb_pc_gen;

`ifdef PC_MISALIGN_CHK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_fetch_ready = 1'b0;
  logic        o_fetch_valid;
  logic [31:0] o_pc;
  logic        i_trap_valid = 1'b0;
  logic [31:0] i_trap_pc = 32'h0;
  logic        i_br_valid = 1'b0;
  logic [31:0] i_br_pc = 32'h0;
  logic        i_halt = 1'b0;
  logic        o_halted;
  logic        o_misalign;
  logic [31:0] o_misalign_pc;

  int n_checks = 0;
  int n_err = 0;

  pc_gen dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_fetch_ready(i_fetch_ready), .o_fetch_valid(o_fetch_valid), .o_pc(o_pc),
    .i_trap_valid(i_trap_valid), .i_trap_pc(i_trap_pc),
    .i_br_valid(i_br_valid), .i_br_pc(i_br_pc),
    .i_halt(i_halt), .o_halted(o_halted),
    .o_misalign(o_misalign), .o_misalign_pc(o_misalign_pc)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rdy;
    logic        tv;
    logic [31:0] tpc;
    logic        bv;
    logic [31:0] bpc;
    logic        hlt;
    logic [31:0] epc;
    logic        ev;
    logic        eh;
    logic        em;
  } vec_t;

  function automatic vec_t mk(logic rdy, logic tv, logic [31:0] tpc, logic bv, logic [31:0] bpc,
                              logic hlt, logic [31:0] epc, logic ev, logic eh, logic em);
    vec_t v;
    v.rdy = rdy; v.tv = tv; v.tpc = tpc; v.bv = bv; v.bpc = bpc; v.hlt = hlt;
    v.epc = epc; v.ev = ev; v.eh = eh; v.em = em;
    return v;
  endfunction

  vec_t tbl [29];

  // ---------------- rule-level reference model ----------------
  typedef struct { logic [31:0] addr; bit is_trap; } redir_t;
  redir_t      m_pend[$];
  int          m_mode;      // 0 boot, 1 run, 2 halt
  logic [31:0] m_pc;
  bit          m_mis;
  logic [31:0] m_mis_pc;

  task automatic model_reset();
    m_mode = 0; m_pc = 32'h0; m_pend.delete(); m_mis = 1'b0; m_mis_pc = 32'h0;
  endtask

  task automatic model_step(input bit rdy, input bit tv, input logic [31:0] tpc,
                            input bit bv, input logic [31:0] bpc, input bit hlt);
    bit issuing, waiting, bad_br, use_br;
    logic [31:0] ttgt, btgt;
    redir_t r;
    issuing = (m_mode == 1);
    waiting = issuing && !rdy;
    bad_br  = bv && ((bpc % 32'd4) != 32'd0);
    use_br  = EN ? (bv && !bad_br) : bv;
    ttgt    = (tpc / 32'd4) * 32'd4;
    btgt    = EN ? bpc : (bpc / 32'd4) * 32'd4;
    if (waiting) begin
      if (tv) begin
        r.addr = ttgt; r.is_trap = 1'b1; m_pend.delete(); m_pend.push_back(r);
      end else if (use_br && (m_pend.size() == 0 || !m_pend[0].is_trap)) begin
        r.addr = btgt; r.is_trap = 1'b0; m_pend.delete(); m_pend.push_back(r);
      end
    end else begin
      if (tv) m_pc = ttgt;
      else if (use_br) m_pc = btgt;
      else if (m_pend.size() != 0) m_pc = m_pend[0].addr;
      else if (issuing && rdy) m_pc = m_pc + 32'd4;
      m_pend.delete();
    end
    m_mis    = EN && bad_br;
    m_mis_pc = m_mis ? bpc : 32'h0;
    if (m_mode == 1) m_mode = (hlt && !waiting) ? 2 : 1;
    else             m_mode = hlt ? 2 : 1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
    else if (r < 7) return $urandom & 32'hFFFF_FFFC;
    else return $urandom;
  endfunction

  task automatic drive(input bit rdy, input bit tv, input logic [31:0] tpc,
                       input bit bv, input logic [31:0] bpc, input bit hlt);
    i_fetch_ready = rdy; i_trap_valid = tv; i_trap_pc = tpc;
    i_br_valid = bv; i_br_pc = bpc; i_halt = hlt;
  endtask

  initial begin
    bit rdy, tv, bv, hlt;
    logic [31:0] tpc, bpc;

    tbl[0]  = mk(1, 0, 0,          0, 0,            0, 32'h0,        1, 0, 0);
    tbl[1]  = mk(1, 0, 0,          0, 0,            0, 32'h4,        1, 0, 0);
    tbl[2]  = mk(1, 0, 0,          0, 0,            0, 32'h8,        1, 0, 0);
    tbl[3]  = mk(1, 0, 0,          0, 0,            0, 32'hC,        1, 0, 0);
    tbl[4]  = mk(1, 0, 0,          0, 0,            0, 32'h10,       1, 0, 0);
    tbl[5]  = mk(0, 0, 0,          1, 32'h200,      0, 32'h10,       1, 0, 0);
    tbl[6]  = mk(1, 0, 0,          0, 0,            0, 32'h200,      1, 0, 0);
    tbl[7]  = mk(0, 0, 0,          1, 32'h200,      0, 32'h200,      1, 0, 0);
    tbl[8]  = mk(0, 1, 32'h80,     0, 0,            0, 32'h200,      1, 0, 0);
    tbl[9]  = mk(1, 0, 0,          0, 0,            0, 32'h80,       1, 0, 0);
    tbl[10] = mk(0, 1, 32'h80,     0, 0,            0, 32'h80,       1, 0, 0);
    tbl[11] = mk(0, 0, 0,          1, 32'h200,      0, 32'h80,       1, 0, 0);
    tbl[12] = mk(1, 0, 0,          0, 0,            0, 32'h80,       1, 0, 0);
    tbl[13] = mk(1, 1, 32'h80,     1, 32'h300,      0, 32'h80,       1, 0, 0);
    tbl[14] = mk(1, 1, 32'hA3,     0, 0,            0, 32'hA0,       1, 0, 0);
    tbl[15] = mk(1, 0, 0,          1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 1, 0, 0);
    tbl[16] = mk(1, 0, 0,          0, 0,            0, 32'h0,        1, 0, 0);
    tbl[17] = mk(1, 0, 0,          1, 32'h40,       0, 32'h40,       1, 0, 0);
    tbl[18] = mk(0, 0, 0,          0, 0,            1, 32'h40,       1, 0, 0);
    tbl[19] = mk(0, 0, 0,          0, 0,            1, 32'h40,       1, 0, 0);
    tbl[20] = mk(1, 0, 0,          0, 0,            1, 32'h44,       0, 1, 0);
    tbl[21] = mk(1, 0, 0,          1, 32'h100,      1, 32'h100,      0, 1, 0);
    tbl[22] = mk(1, 0, 0,          0, 0,            0, 32'h100,      1, 0, 0);
    tbl[23] = mk(1, 0, 0,          0, 0,            0, 32'h104,      1, 0, 0);
    tbl[24] = mk(0, 0, 0,          1, 32'h500,      0, 32'h104,      1, 0, 0);
    tbl[25] = mk(1, 0, 0,          1, 32'h600,      0, 32'h600,      1, 0, 0);
    tbl[26] = mk(1, 0, 0,          0, 0,            0, 32'h604,      1, 0, 0);
    tbl[27] = mk(1, 0, 0,          1, 32'h102,      0, EN ? 32'h608 : 32'h100, 1, 0, EN);
    tbl[28] = mk(1, 0, 0,          0, 0,            0, EN ? 32'h60C : 32'h104, 1, 0, 0);

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_pc", o_pc, 32'h0);
    chk("reset_valid", 32'(o_fetch_valid), 32'h0);
    chk("reset_halted", 32'(o_halted), 32'h0);
    chk("reset_misalign", 32'(o_misalign), 32'h0);
    chk("reset_misalign_pc", o_misalign_pc, 32'h0);

    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk("boot_valid", 32'(o_fetch_valid), 32'h0);

    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].rdy, tbl[i].tv, tbl[i].tpc, tbl[i].bv, tbl[i].bpc, tbl[i].hlt);
      @(posedge i_clk);
      #1;
      chk($sformatf("vec%0d_pc", i), o_pc, tbl[i].epc);
      chk($sformatf("vec%0d_valid", i), 32'(o_fetch_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_halted", i), 32'(o_halted), 32'(tbl[i].eh));
      chk($sformatf("vec%0d_misalign", i), 32'(o_misalign), 32'(tbl[i].em));
      chk($sformatf("vec%0d_misalign_pc", i), o_misalign_pc, tbl[i].em ? tbl[i].bpc : 32'h0);
    end

    // Reset in the middle of a stalled handshake with a pending redirect
    drive(0, 0, 0, 1, 32'h700, 0);
    @(posedge i_clk);
    #1;
    chk("stall_before_reset_valid", 32'(o_fetch_valid), 32'h1);
    rst_async_check();
    drive(1, 0, 0, 0, 0, 1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("boot_to_halt_halted", 32'(o_halted), 32'h1);
    chk("boot_to_halt_valid", 32'(o_fetch_valid), 32'h0);
    chk("boot_to_halt_pc", o_pc, 32'h0);
    drive(1, 0, 0, 0, 0, 0);
    @(posedge i_clk);
    #1;
    chk("resume_valid", 32'(o_fetch_valid), 32'h1);
    chk("resume_pc_pending_dropped", o_pc, 32'h0);
    @(posedge i_clk);
    #1;
    chk("resume_first_inc", o_pc, 32'h4);

    // Randomized run against the reference model
    i_rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    hlt = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 9) < 7);
      tv  = ($urandom_range(0, 19) == 0);
      bv  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) hlt = !hlt;
      tpc = $urandom;
      bpc = rand_addr();
      drive(rdy, tv, tpc, bv, bpc, hlt);
      @(posedge i_clk);
      model_step(rdy, tv, tpc, bv, bpc, hlt);
      #1;
      chk("rand_pc", o_pc, m_pc);
      chk("rand_valid", 32'(o_fetch_valid), 32'(m_mode == 1));
      chk("rand_halted", 32'(o_halted), 32'(m_mode == 2));
      chk("rand_misalign", 32'(o_misalign), 32'(m_mis));
      chk("rand_misalign_pc", o_misalign_pc, m_mis_pc);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  task automatic rst_async_check();
    i_rst_n = 1'b0;
    #1;
    chk("async_reset_pc", o_pc, 32'h0);
    chk("async_reset_valid", 32'(o_fetch_valid), 32'h0);
  endtask

endmodule
